uart_io_fifo: RTL and testbench
===============================

UART_IO_FIFO -- requirements
Module: uart_io_fifo

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 25000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, line rate in bit/s.
REQ-003 SHALL have parameter TX_DEPTH, default 16, TX FIFO entries, power of two, 2..256.
REQ-004 SHALL have parameter RX_DEPTH, default 16, RX FIFO entries, power of two, 2..256.
REQ-005 SHALL have port i_clk  input  1  single system clock, all logic on rising edge.
REQ-006 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port i_addr  input  2  register word offset: 0 DATA, 1 STATUS, 2 LEVEL, 3 reserved.
REQ-008 SHALL have port i_wdata  input  32  write data.
REQ-009 SHALL have port i_wstrb  input  1  write strobe, one-cycle pulse.
REQ-010 SHALL have port i_rstrb  input  1  read strobe, one-cycle pulse.
REQ-011 SHALL have port o_rdata  output  32  registered read data.
REQ-012 SHALL have port o_uart_tx  output  1  serial TX line, idle high.
REQ-013 SHALL have port i_uart_rx  input  1  serial RX line, asynchronous.
REQ-014 SHALL have port o_irq  output  1  high while RX FIFO non-empty or TX FIFO empty.

Function
REQ-015 SHALL use bit period DIV = CLK_FREQ_HZ/BAUD_RATE, integer truncation (217 at defaults).
REQ-016 SHALL, on i_wstrb at DATA, push i_wdata[7:0] into the TX FIFO if it is not full that cycle; otherwise drop the byte and set sticky tx_ovf.
REQ-017 SHALL treat a pop in the same cycle as a push to a full TX FIFO as not freeing space: the push is dropped.
REQ-018 SHALL run the TX FSM IDLE->START->DATA->STOP->IDLE, each state lasting DIV cycles per bit, 8N1, LSB first.
REQ-019 SHALL pop the TX FIFO in IDLE when non-empty, drive the start bit from the next cycle, and return to IDLE after the stop bit.
REQ-020 SHALL send back-to-back frames with no idle bit time when the FIFO holds further data.
REQ-021 SHALL present o_rdata one cycle after i_rstrb and hold it until the next i_rstrb.
REQ-022 SHALL, on DATA read, return {23'b0, rx_valid, byte}, pop one RX entry if non-empty, and return 0 without popping when empty.
REQ-023 SHALL return on STATUS read: bit0 tx_full, bit1 tx_empty, bit2 rx_valid, bit3 rx_ovr, bit4 rx_ferr, bit5 tx_ovf, bit9 busy (TX FIFO non-empty or FSM not IDLE), others 0.
REQ-024 SHALL clear sticky bits rx_ovr, rx_ferr and tx_ovf in the cycle after a STATUS read, with a same-cycle set winning over the clear.
REQ-025 SHALL return on LEVEL read: [8:0] TX occupancy, [24:16] RX occupancy; reserved offset reads 0 and ignores writes.
REQ-026 SHALL keep FIFO pointers one bit wider than log2(depth), wrapping modulo 2*depth; full when MSBs differ and the rest are equal.

Reset
REQ-027 SHALL, while i_rst is high, empty both FIFOs, set the TX FSM to IDLE, drive o_uart_tx=1 and o_rdata=0, clear sticky bits, and force the RX FSM to IDLE.
REQ-028 SHALL, on reset mid-frame, abort the frame in that cycle, with the partial TX frame cut short and the partial RX byte discarded.
REQ-029 SHALL evaluate o_irq combinationally from reset state, giving o_irq=1 after reset (TX empty).

Configuration
REQ-030 SHALL compile the receiver, RX FIFO and their status bits only when macro UART_IO_FIFO_RX_EN is defined.
REQ-031 SHALL, with UART_IO_FIFO_RX_EN defined, run the RX path: 2-flop synchronizer, falling edge -> wait DIV/2 and require low (else false start, back to IDLE), sample 8 bits at DIV intervals, sample stop bit.
REQ-032 SHALL, with UART_IO_FIFO_RX_EN defined, discard the byte and set rx_ferr when stop=0, and discard the byte and set rx_ovr when the RX FIFO is full.
REQ-033 SHALL, without UART_IO_FIFO_RX_EN, leave i_uart_rx unconnected, read DATA as 0, read STATUS bits 2-4 and LEVEL[24:16] as 0, and drive o_irq from TX empty only.

Verification
REQ-034 SHALL cover, with CLK_FREQ_HZ=1000000 and BAUD_RATE=100000 (DIV=10): write 0x55 to DATA -> tx low 10 cycles, then 1,0,1,0,1,0,1,0 at 10 cycles each, then stop high; frame complete 100 cycles after first tx low.
REQ-035 SHALL cover: with TX_DEPTH=4, write 6 bytes in consecutive cycles -> 5 accepted (one popped immediately), tx_ovf=1, STATUS bit9=1 until the last stop bit; a second STATUS read shows tx_ovf=0.
REQ-036 SHALL cover, with RX enabled: drive 0xA3 8N1 on rx -> DATA read returns 0x1A3; a next DATA read returns 0x000.
REQ-037 SHALL cover, with RX enabled: a 3-cycle low glitch on rx -> no byte and no error; a frame with stop=0 -> rx_ferr=1 and RX level 0.
REQ-038 SHALL cover: assert i_rst at cycle 40 of a TX frame -> o_uart_tx=1 the next cycle, LEVEL=0, STATUS=0x002.

Source files
------------

// File: rtl/uart_io_fifo.sv
// Memory-mapped UART with TX/RX byte FIFOs, 8N1, fixed divider CLK_FREQ_HZ/BAUD_RATE.
// The receiver path is built only when UART_IO_FIFO_RX_EN is defined.
module uart_io_fifo #(
   parameter int unsigned CLK_FREQ_HZ = 25000000,
   parameter int unsigned BAUD_RATE   = 115200,
   parameter int unsigned TX_DEPTH    = 16,
   parameter int unsigned RX_DEPTH    = 16
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [1:0]  i_addr,
   input  logic [31:0] i_wdata,
   input  logic        i_wstrb,
   input  logic        i_rstrb,
   output logic [31:0] o_rdata,
   output logic        o_uart_tx,
   input  logic        i_uart_rx,
   output logic        o_irq
);

   localparam int unsigned DIV      = CLK_FREQ_HZ / BAUD_RATE;
   localparam int unsigned TX_AW    = $clog2(TX_DEPTH);
   localparam logic [31:0] DIV_LAST = 32'(DIV - 1);
   localparam logic [TX_AW:0] TX_ONE = (TX_AW + 1)'(1);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

   logic        wr_data, rd_data, rd_status;
   logic [23:0] unused_wdata;

   assign wr_data      = i_wstrb && (i_addr == 2'd0);
   assign rd_data      = i_rstrb && (i_addr == 2'd0);
   assign rd_status    = i_rstrb && (i_addr == 2'd1);
   assign unused_wdata = i_wdata[31:8];

   // ---------------- TX FIFO ----------------
   logic [7:0]     tx_mem_q [TX_DEPTH];
   logic [TX_AW:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d, tx_level;
   logic           tx_full, tx_empty, tx_push, tx_pop, tx_busy;
   logic           tx_ovf_q, tx_ovf_d;

   assign tx_level = tx_wp_q - tx_rp_q;
   assign tx_empty = (tx_wp_q == tx_rp_q);
   assign tx_full  = (tx_wp_q[TX_AW] != tx_rp_q[TX_AW]) &&
                     (tx_wp_q[TX_AW-1:0] == tx_rp_q[TX_AW-1:0]);
   // Fullness is judged on the registered pointers, so a same-cycle pop never makes room.
   assign tx_push  = wr_data && !tx_full;

   // ---------------- TX FSM ----------------
   tx_state_e   tx_state_q;
   logic [31:0] tx_cnt_q;
   logic [2:0]  tx_bit_q;
   logic [7:0]  tx_shift_q;
   logic        tx_line_q;
   logic        tx_cnt_done;

   assign tx_cnt_done = (tx_cnt_q == DIV_LAST);
   assign tx_pop  = !tx_empty &&
                    ((tx_state_q == TX_IDLE) || ((tx_state_q == TX_STOP) && tx_cnt_done));
   assign tx_busy = !tx_empty || (tx_state_q != TX_IDLE);
   assign o_uart_tx = tx_line_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_line_q  <= 1'b1;
      end else begin
         case (tx_state_q)
            TX_IDLE: begin
               if (tx_pop) begin
                  tx_shift_q <= tx_mem_q[tx_rp_q[TX_AW-1:0]];
                  tx_cnt_q   <= '0;
                  tx_line_q  <= 1'b0;
                  tx_state_q <= TX_START;
               end
            end
            TX_START: begin
               if (tx_cnt_done) begin
                  tx_cnt_q   <= '0;
                  tx_bit_q   <= '0;
                  tx_line_q  <= tx_shift_q[0];
                  tx_state_q <= TX_DATA;
               end else begin
                  tx_cnt_q <= tx_cnt_q + 32'd1;
               end
            end
            TX_DATA: begin
               if (tx_cnt_done) begin
                  tx_cnt_q <= '0;
                  if (tx_bit_q == 3'd7) begin
                     tx_line_q  <= 1'b1;
                     tx_state_q <= TX_STOP;
                  end else begin
                     tx_bit_q   <= tx_bit_q + 3'd1;
                     tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                     tx_line_q  <= tx_shift_q[1];
                  end
               end else begin
                  tx_cnt_q <= tx_cnt_q + 32'd1;
               end
            end
            TX_STOP: begin
               if (tx_cnt_done) begin
                  tx_cnt_q <= '0;
                  // Chain straight into the next start bit when more data is queued.
                  if (tx_pop) begin
                     tx_shift_q <= tx_mem_q[tx_rp_q[TX_AW-1:0]];
                     tx_line_q  <= 1'b0;
                     tx_state_q <= TX_START;
                  end else begin
                     tx_state_q <= TX_IDLE;
                  end
               end else begin
                  tx_cnt_q <= tx_cnt_q + 32'd1;
               end
            end
            default: tx_state_q <= TX_IDLE;
         endcase
      end
   end

   // ---------------- RX path ----------------
   logic       rx_valid, rx_ovr, rx_ferr;
   logic [7:0] rx_head;
   logic [8:0] rx_level9;

`ifdef UART_IO_FIFO_RX_EN
   localparam int unsigned RX_AW     = $clog2(RX_DEPTH);
   localparam logic [31:0] HALF_LAST = 32'((DIV / 2) - 1);
   localparam logic [RX_AW:0] RX_ONE = (RX_AW + 1)'(1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

   logic [7:0]     rx_mem_q [RX_DEPTH];
   logic [RX_AW:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d, rx_level;
   logic           rx_full, rx_empty, rx_push, rx_pop, rx_done;
   logic           rx_ovr_q, rx_ovr_d, rx_ferr_q, rx_ferr_d;
   logic           rx_s1_q, rx_s2_q, rx_s3_q;
   rx_state_e      rx_state_q;
   logic [31:0]    rx_cnt_q;
   logic [2:0]     rx_bit_q;
   logic [7:0]     rx_shift_q;

   assign rx_level  = rx_wp_q - rx_rp_q;
   assign rx_empty  = (rx_wp_q == rx_rp_q);
   assign rx_full   = (rx_wp_q[RX_AW] != rx_rp_q[RX_AW]) &&
                      (rx_wp_q[RX_AW-1:0] == rx_rp_q[RX_AW-1:0]);
   assign rx_done   = (rx_state_q == RX_STOP) && (rx_cnt_q == DIV_LAST);
   assign rx_push   = rx_done && rx_s2_q && !rx_full;
   assign rx_pop    = rd_data && !rx_empty;
   assign rx_valid  = !rx_empty;
   assign rx_head   = rx_mem_q[rx_rp_q[RX_AW-1:0]];
   assign rx_level9 = 9'(rx_level);
   assign rx_ovr    = rx_ovr_q;
   assign rx_ferr   = rx_ferr_q;

   always_comb begin
      rx_wp_d = rx_wp_q;
      rx_rp_d = rx_rp_q;
      if (rx_push) rx_wp_d = rx_wp_q + RX_ONE;
      if (rx_pop)  rx_rp_d = rx_rp_q + RX_ONE;
      rx_ovr_d  = rd_status ? 1'b0 : rx_ovr_q;
      rx_ferr_d = rd_status ? 1'b0 : rx_ferr_q;
      if (rx_done && rx_s2_q && rx_full) rx_ovr_d = 1'b1;
      if (rx_done && !rx_s2_q)           rx_ferr_d = 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_s3_q    <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_wp_q    <= '0;
         rx_rp_q    <= '0;
         rx_ovr_q   <= 1'b0;
         rx_ferr_q  <= 1'b0;
      end else begin
         rx_s1_q   <= i_uart_rx;
         rx_s2_q   <= rx_s1_q;
         rx_s3_q   <= rx_s2_q;
         rx_wp_q   <= rx_wp_d;
         rx_rp_q   <= rx_rp_d;
         rx_ovr_q  <= rx_ovr_d;
         rx_ferr_q <= rx_ferr_d;
         case (rx_state_q)
            RX_IDLE: begin
               if (rx_s3_q && !rx_s2_q) begin
                  rx_cnt_q   <= '0;
                  rx_state_q <= RX_START;
               end
            end
            RX_START: begin
               if (rx_cnt_q == HALF_LAST) begin
                  rx_cnt_q   <= '0;
                  rx_bit_q   <= '0;
                  rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt_q <= rx_cnt_q + 32'd1;
               end
            end
            RX_DATA: begin
               if (rx_cnt_q == DIV_LAST) begin
                  rx_cnt_q   <= '0;
                  rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                  rx_bit_q   <= rx_bit_q + 3'd1;
                  if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
               end else begin
                  rx_cnt_q <= rx_cnt_q + 32'd1;
               end
            end
            RX_STOP: begin
               if (rx_cnt_q == DIV_LAST) begin
                  rx_cnt_q   <= '0;
                  rx_state_q <= RX_IDLE;
               end else begin
                  rx_cnt_q <= rx_cnt_q + 32'd1;
               end
            end
            default: rx_state_q <= RX_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (rx_push) rx_mem_q[rx_wp_q[RX_AW-1:0]] <= rx_shift_q;
   end
`else
   logic unused_rx;

   assign unused_rx = i_uart_rx;
   assign rx_valid  = 1'b0;
   assign rx_ovr    = 1'b0;
   assign rx_ferr   = 1'b0;
   assign rx_head   = '0;
   assign rx_level9 = '0;
`endif

   // ---------------- register file ----------------
   logic [31:0] rdata_q, rdata_d;

   always_comb begin
      tx_wp_d = tx_wp_q;
      tx_rp_d = tx_rp_q;
      if (tx_push) tx_wp_d = tx_wp_q + TX_ONE;
      if (tx_pop)  tx_rp_d = tx_rp_q + TX_ONE;
      tx_ovf_d = rd_status ? 1'b0 : tx_ovf_q;
      if (wr_data && tx_full) tx_ovf_d = 1'b1;
      rdata_d = rdata_q;
      if (i_rstrb) begin
         case (i_addr)
            2'd0:    rdata_d = rx_valid ? {23'b0, 1'b1, rx_head} : '0;
            2'd1:    rdata_d = {22'b0, tx_busy, 3'b0, tx_ovf_q, rx_ferr, rx_ovr,
                                rx_valid, tx_empty, tx_full};
            2'd2:    rdata_d = {7'b0, rx_level9, 7'b0, 9'(tx_level)};
            default: rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         tx_wp_q  <= '0;
         tx_rp_q  <= '0;
         tx_ovf_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         tx_wp_q  <= tx_wp_d;
         tx_rp_q  <= tx_rp_d;
         tx_ovf_q <= tx_ovf_d;
         rdata_q  <= rdata_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (tx_push) tx_mem_q[tx_wp_q[TX_AW-1:0]] <= i_wdata[7:0];
   end

   assign o_rdata = rdata_q;
   assign o_irq   = rx_valid || tx_empty;

endmodule

// File: tb/tb_uart_io_fifo.sv
// Directed + randomized bench for uart_io_fifo at DIV=10, TX_DEPTH=4; RX cases run when UART_IO_FIFO_RX_EN is defined.
module tb_uart_io_fifo;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned BIT_T = 10;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  addr = '0;
   logic [31:0] wdata = '0;
   logic        wstrb = 1'b0;
   logic        rstrb = 1'b0;
   logic [31:0] rdata;
   logic        uart_tx;
   logic        uart_rx = 1'b1;
   logic        irq;

   int n_checks = 0;
   int n_pass   = 0;
   logic [7:0] exp_q[$];

   uart_io_fifo #(
      .CLK_FREQ_HZ(1000000),
      .BAUD_RATE  (100000),
      .TX_DEPTH   (DEPTH),
      .RX_DEPTH   (DEPTH)
   ) dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_addr   (addr),
      .i_wdata  (wdata),
      .i_wstrb  (wstrb),
      .i_rstrb  (rstrb),
      .o_rdata  (rdata),
      .o_uart_tx(uart_tx),
      .i_uart_rx(uart_rx),
      .o_irq    (irq)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      addr  = a;
      wdata = d;
      wstrb = 1'b1;
      tick();
      wstrb = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      addr  = a;
      rstrb = 1'b1;
      tick();
      rstrb = 1'b0;
      d = rdata;
   endtask

   // Decode one 8N1 frame from the TX line at mid-bit and compare with the model queue.
   task automatic recv_frame(input string tag, input bit chk_gap);
      int         waited;
      logic [7:0] got;
      logic [31:0] exp;
      waited = 0;
      while (uart_tx !== 1'b0 && waited < 400) begin
         tick();
         waited++;
      end
      check({tag, "_start_seen"}, {31'b0, uart_tx}, 32'd0);
      if (chk_gap) check({tag, "_gap"}, waited, 32'd5);
      repeat (BIT_T / 2) tick();
      check({tag, "_start_mid"}, {31'b0, uart_tx}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         repeat (BIT_T) tick();
         got[i] = uart_tx;
      end
      repeat (BIT_T) tick();
      check({tag, "_stop"}, {31'b0, uart_tx}, 32'd1);
      exp = (exp_q.size() != 0) ? {24'b0, exp_q.pop_front()} : 32'h100;
      check({tag, "_byte"}, {24'b0, got}, exp);
   endtask

`ifdef UART_IO_FIFO_RX_EN
   task automatic drive_rx(input logic [7:0] b, input logic stop);
      uart_rx = 1'b0;
      repeat (BIT_T) tick();
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (BIT_T) tick();
      end
      uart_rx = stop;
      repeat (BIT_T) tick();
      uart_rx = 1'b1;
   endtask
`endif

   initial begin
      logic [31:0] d;
      logic [9:0]  frame;
      logic [7:0]  bytes [6];
      int          waited, n, low_cnt;

      // Reset state
      repeat (2) tick();
      check("rst_tx", {31'b0, uart_tx}, 32'd1);
      check("rst_rdata", rdata, 32'd0);
      check("rst_irq", {31'b0, irq}, 32'd1);
      rst = 1'b0;
      tick();
      rd(2'd1, d); check("rst_status", d, 32'h002);
      rd(2'd2, d); check("rst_level", d, 32'h0);
      rd(2'd3, d); check("reserved_rd", d, 32'h0);
      wr(2'd3, 32'hFF);
      rd(2'd2, d); check("reserved_wr_level", d, 32'h0);

      // Exact waveform of one 0x55 frame
      wr(2'd0, 32'h155);
      waited = 0;
      while (uart_tx !== 1'b0 && waited < 20) begin
         tick();
         waited++;
      end
      check("t55_latency", waited, 32'd1);
      frame = {1'b1, 8'h55, 1'b0};
      for (int k = 0; k < 10 * BIT_T; k++) begin
         check("t55_bit", {31'b0, uart_tx}, {31'b0, frame[k / BIT_T]});
         tick();
      end
      check("t55_idle", {31'b0, uart_tx}, 32'd1);
      rd(2'd1, d); check("t55_status_done", d, 32'h002);

      // Overflow: six back-to-back writes into a 4-entry FIFO
      for (int i = 0; i < 6; i++) begin
         bytes[i] = 8'($urandom);
         if (i < DEPTH + 1) exp_q.push_back(bytes[i]);
      end
      fork
         begin
            logic [31:0] s;
            for (int i = 0; i < 6; i++) wr(2'd0, {24'hABCDEF, bytes[i]});
            rd(2'd1, s); check("ovf_status1", s, 32'h221);
            check("ovf_irq", {31'b0, irq}, 32'd0);
            rd(2'd2, s); check("ovf_level", s, 32'h4);
            rd(2'd1, s); check("ovf_status2", s, 32'h201);
         end
         begin
            for (int i = 0; i < DEPTH + 1; i++) recv_frame("ovf", i > 0);
         end
      join
      rd(2'd1, d); check("ovf_busy_in_stop", d, 32'h202);
      repeat (BIT_T) tick();
      rd(2'd1, d); check("ovf_idle", d, 32'h002);
      check("ovf_queue_drained", exp_q.size(), 32'd0);

      // Randomized bursts with random spacing
      for (int r = 0; r < 6; r++) begin
         n = $urandom_range(1, DEPTH + 1);
         for (int i = 0; i < n; i++) begin
            bytes[i] = 8'($urandom);
            exp_q.push_back(bytes[i]);
         end
         fork
            begin
               for (int i = 0; i < n; i++) begin
                  wr(2'd0, {24'b0, bytes[i]});
                  repeat ($urandom_range(0, 3)) tick();
               end
            end
            begin
               for (int i = 0; i < n; i++) recv_frame("rand", i > 0);
            end
         join
         repeat (BIT_T) tick();
         rd(2'd1, d); check("rand_status", d, 32'h002);
      end

      // Reset mid-frame
      wr(2'd0, 32'h0F);
      waited = 0;
      while (uart_tx !== 1'b0 && waited < 20) begin
         tick();
         waited++;
      end
      wr(2'd0, 32'h33);
      wr(2'd0, 32'h44);
      repeat (38) tick();
      rst = 1'b1;
      tick();
      check("rstmid_tx", {31'b0, uart_tx}, 32'd1);
      check("rstmid_rdata", rdata, 32'd0);
      check("rstmid_irq", {31'b0, irq}, 32'd1);
      rst = 1'b0;
      rd(2'd2, d); check("rstmid_level", d, 32'h0);
      rd(2'd1, d); check("rstmid_status", d, 32'h002);
      low_cnt = 0;
      for (int i = 0; i < 120; i++) begin
         if (uart_tx !== 1'b1) low_cnt++;
         tick();
      end
      check("rstmid_line_quiet", low_cnt, 32'd0);

`ifdef UART_IO_FIFO_RX_EN
      drive_rx(8'hA3, 1'b1);
      repeat (5) tick();
      check("rx_irq", {31'b0, irq}, 32'd1);
      rd(2'd2, d); check("rx_level1", d, 32'h0001_0000);
      rd(2'd0, d); check("rx_data", d, 32'h1A3);
      rd(2'd0, d); check("rx_data_empty", d, 32'h0);
      uart_rx = 1'b0;
      repeat (3) tick();
      uart_rx = 1'b1;
      repeat (30) tick();
      rd(2'd1, d); check("rx_glitch_status", d, 32'h002);
      rd(2'd2, d); check("rx_glitch_level", d, 32'h0);
      drive_rx(8'h5A, 1'b0);
      repeat (10) tick();
      rd(2'd1, d); check("rx_ferr_status", d, 32'h012);
      rd(2'd2, d); check("rx_ferr_level", d, 32'h0);
      rd(2'd1, d); check("rx_ferr_cleared", d, 32'h002);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
